// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and counter widths used by the
// rules stage, the game FSM and the display path.
package game_pkg;

    localparam int SCORE_W = 8;
    localparam int LIVES_W = 4;
    localparam int TIME_W  = 8;

    // Rules-stage state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } track_state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the countdown timer: counts 0..TICK_DIV-1 while enabled and
// flags the wrap cycle with a one-cycle tick.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // The tick marks the cycle whose edge wraps the counter back to zero.
    assign tick = enable && (cnt == LAST);

    // Clear wins over enable; with neither the count is frozen.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Game-rules stage: tracks score, lives and the countdown during play and
// produces the win/lose levels consumed by the top-level game FSM.
module score_tracker
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int TARGET_SCORE = 50,
    parameter int START_LIVES  = 3,
    parameter int GAME_SECONDS = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               q_start,
    input  logic               q_playing,
    input  logic               hit,
    input  logic               miss,
    output logic               win,
    output logic               lose,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [TIME_W-1:0]  time_left
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(TARGET_SCORE);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(GAME_SECONDS);

    track_state_t       state, state_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [TIME_W-1:0]  time_nxt;
    logic               tick, tick_en, tick_clr;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    // Flags decode straight from the registered state, so they can never
    // both be high and they track the counters that decided them.
    assign win  = (state == ST_WON);
    assign lose = (state == ST_LOST);

    // State and counter registers; reset lands on the reload values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            score     <= '0;
            lives     <= LIVES_INIT;
            time_left <= TIME_INIT;
        end else begin
            state     <= state_nxt;
            score     <= score_nxt;
            lives     <= lives_nxt;
            time_left <= time_nxt;
        end
    end

    // Next-state and counter updates. The RUN exit decision looks at the
    // updated counter values, so a win on the same edge as the last miss or
    // the last tick still counts as a win.
    always_comb begin
        state_nxt = state;
        score_nxt = score;
        lives_nxt = lives;
        time_nxt  = time_left;
        tick_en   = 1'b0;
        tick_clr  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // Held at the reload values; prescaler parked at zero so
                // the first second of play is a full TICK_DIV cycles.
                score_nxt = '0;
                lives_nxt = LIVES_INIT;
                time_nxt  = TIME_INIT;
                tick_clr  = 1'b1;
                if (q_playing && !q_start) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (q_start) begin
                    // Abort: back to IDLE without reporting a result.
                    state_nxt = ST_IDLE;
                    score_nxt = '0;
                    lives_nxt = LIVES_INIT;
                    time_nxt  = TIME_INIT;
                    tick_clr  = 1'b1;
                end else if (q_playing) begin
                    tick_en = 1'b1;
                    if (hit && (score != SCORE_MAX)) begin
                        score_nxt = score + SCORE_W'(1);
                    end
                    if (miss && (lives != '0)) begin
                        lives_nxt = lives - LIVES_W'(1);
                    end
                    if (tick && (time_left != '0)) begin
                        time_nxt = time_left - TIME_W'(1);
                    end
                    if (score_nxt == SCORE_MAX) begin
                        state_nxt = ST_WON;
                    end else if ((lives_nxt == '0) || (time_nxt == '0)) begin
                        state_nxt = ST_LOST;
                    end
                end
                // Otherwise the FSM has already left PLAYING: hold everything.
            end

            ST_WON, ST_LOST: begin
                // Result frozen until the FSM re-arms through START.
                if (q_start) begin
                    state_nxt = ST_IDLE;
                    score_nxt = '0;
                    lives_nxt = LIVES_INIT;
                    time_nxt  = TIME_INIT;
                    tick_clr  = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed scenarios with literal
// expectations, then randomized play checked every cycle against a model.
module tb_score_tracker;

    localparam int TICK_DIV     = 4;
    localparam int TARGET_SCORE = 3;
    localparam int START_LIVES  = 2;
    localparam int GAME_SECONDS = 5;

    localparam int M_IDLE = 0, M_RUN = 1, M_WON = 2, M_LOST = 3;

    logic       clk = 1'b0;
    logic       reset, q_start, q_playing, hit, miss;
    logic       win, lose;
    logic [7:0] score;
    logic [3:0] lives;
    logic [7:0] time_left;

    int n_checks = 0;
    int n_fail   = 0;

    score_tracker #(
        .TICK_DIV     (TICK_DIV),
        .TARGET_SCORE (TARGET_SCORE),
        .START_LIVES  (START_LIVES),
        .GAME_SECONDS (GAME_SECONDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .q_start   (q_start),
        .q_playing (q_playing),
        .hit       (hit),
        .miss      (miss),
        .win       (win),
        .lose      (lose),
        .score     (score),
        .lives     (lives),
        .time_left (time_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: game phase, counters, and active play cycles since
    // RUN entry; time remaining is derived from whole seconds elapsed.
    int m_st, m_score, m_lives, m_time, m_active;
    bit m_valid = 1'b0;

    task automatic m_reload();
        m_st = M_IDLE; m_score = 0; m_lives = START_LIVES;
        m_time = GAME_SECONDS; m_active = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_reload();
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_st)
                M_IDLE: begin
                    m_reload();
                    if (q_playing && !q_start) m_st = M_RUN;
                end
                M_RUN: begin
                    if (q_start) begin
                        m_reload();
                    end else if (q_playing) begin
                        m_active++;
                        if (hit && m_score < TARGET_SCORE) m_score++;
                        if (miss && m_lives > 0) m_lives--;
                        m_time = GAME_SECONDS - m_active / TICK_DIV;
                        if (m_time < 0) m_time = 0;
                        if (m_score == TARGET_SCORE) m_st = M_WON;
                        else if (m_lives == 0 || m_time == 0) m_st = M_LOST;
                    end
                end
                default: if (q_start) m_reload();
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("win",       int'(win),       int'(m_st == M_WON));
            check("lose",      int'(lose),      int'(m_st == M_LOST));
            check("score",     int'(score),     m_score);
            check("lives",     int'(lives),     m_lives);
            check("time_left", int'(time_left), m_time);
            check("win_lose_excl", int'(win && lose), 0);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rearm_and_run();
        q_playing = 0; q_start = 1; cyc();
        q_start = 0; q_playing = 1; cyc();
    endtask

    task automatic pulse_hit();
        hit = 1; cyc(); hit = 0;
    endtask

    task automatic pulse_miss();
        miss = 1; cyc(); miss = 0;
    endtask

    initial begin
        reset = 1; q_start = 0; q_playing = 0; hit = 0; miss = 0;
        cyc(2);
        check("rst_score", score, 0);
        check("rst_lives", lives, 2);
        check("rst_time",  time_left, 5);
        check("rst_win",   win, 0);
        check("rst_lose",  lose, 0);
        reset = 0;

        // 1: three spaced hits win the game
        rearm_and_run();
        pulse_hit(); check("t1_score1", score, 1); cyc();
        pulse_hit(); check("t1_score2", score, 2); cyc();
        pulse_hit(); check("t1_score3", score, 3);
        check("t1_win", win, 1); check("t1_lose", lose, 0);
        cyc(3); check("t1_win_held", win, 1);
        q_playing = 0; q_start = 1; cyc(); q_start = 0;
        check("t1_rearm_win", win, 0); check("t1_rearm_score", score, 0);

        // 2: two misses lose; later hits ignored
        q_playing = 1; cyc();
        pulse_miss(); check("t2_lives1", lives, 1); check("t2_lose0", lose, 0);
        pulse_miss(); check("t2_lives0", lives, 0); check("t2_lose1", lose, 1);
        pulse_hit(); check("t2_score_frozen", score, 0);

        // 3: timeout after 20 active cycles
        rearm_and_run();
        cyc(4);  check("t3_time4", time_left, 4);
        cyc(15); check("t3_time1", time_left, 1); check("t3_lose_pre", lose, 0);
        cyc();   check("t3_time0", time_left, 0); check("t3_lose", lose, 1);

        // 4: final hit coinciding with last miss is a win
        rearm_and_run();
        pulse_hit(); pulse_hit(); pulse_miss();
        hit = 1; miss = 1; cyc(); hit = 0; miss = 0;
        check("t4_win", win, 1); check("t4_lose", lose, 0); check("t4_lives", lives, 0);

        // 5: abort mid-game
        rearm_and_run();
        pulse_hit(); pulse_hit(); pulse_miss(); cyc(5);
        check("t5_time3", time_left, 3);
        q_playing = 0; q_start = 1; cyc(); q_start = 0;
        check("t5_score", score, 0); check("t5_lives", lives, 2);
        check("t5_time",  time_left, 5);
        check("t5_win", win, 0); check("t5_lose", lose, 0);

        // 6: reset while WON, then hits in IDLE ignored
        rearm_and_run();
        pulse_hit(); pulse_hit(); pulse_hit();
        check("t6_won", win, 1);
        q_playing = 0; reset = 1; cyc(); reset = 0;
        check("t6_win", win, 0); check("t6_score", score, 0);
        check("t6_lives", lives, 2); check("t6_time", time_left, 5);
        pulse_hit(); cyc(); check("t6_idle_hit", score, 0);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            q_start   = ($urandom_range(0, 39) == 0);
            q_playing = !q_start && ($urandom_range(0, 9) < 8);
            hit       = ($urandom_range(0, 3) == 0);
            miss      = ($urandom_range(0, 9) == 0);
            cyc();
        end
        reset = 0; q_start = 0; q_playing = 0; hit = 0; miss = 0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
